// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register width, stage indices and the
// scoreboard entry tracked for each downstream stage.
package pipe_pkg;

    localparam int REG_W    = 4;
    localparam int ALU_OP_W = 4;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    typedef struct packed {
        logic             v;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_entry_t;

    function automatic sb_entry_t sb_bubble();
        sb_entry_t e;
        e.v  = 1'b0;
        e.wr = 1'b0;
        e.rd = {REG_W{1'b0}};
        e.ld = 1'b0;
        return e;
    endfunction

    function automatic logic sb_entry_busy(input sb_entry_t e);
        return e.v & e.wr;
    endfunction

endpackage

// File: rtl/sb_compare.sv
// Compares one ID source operand against every tracked downstream write and
// reports whether that operand cannot be served without stalling.
module sb_compare
    import pipe_pkg::*;
#(
    parameter int DEPTH              = 3,
    parameter int FORWARD            = 1,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  sb_entry_t [DEPTH-1:0] sb_entries_s,
    input  logic [REG_W-1:0]      reg_sel_s,
    input  logic                  use_op_s,
    output logic                  conflict_s
);

    logic [DEPTH-1:0] match_s;
    logic             zero_masked_s;

    // Per-entry destination match, with register 0 optionally excluded
    always_comb begin
        match_s       = {DEPTH{1'b0}};
        zero_masked_s = (ZERO_REG_HARDWIRED != 0) && (reg_sel_s == {REG_W{1'b0}});
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = sb_entries_s[k].v & sb_entries_s[k].wr &
                         (sb_entries_s[k].rd == reg_sel_s) & ~zero_masked_s;
        end
    end

    // With forwarding only a load still in EX is unresolvable
    always_comb begin
        conflict_s = 1'b0;
        if (FORWARD != 0) begin
            conflict_s = use_op_s & match_s[STG_EX] & sb_entries_s[STG_EX].ld;
        end else begin
            conflict_s = use_op_s & (|match_s);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Read-after-write hazard detector: shadows in-flight writes of the downstream
// stages, stalls the IF/ID latch and injects a bubble into EX when needed.
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter int DEPTH              = 3,
    parameter int FORWARD            = 1,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int CNT_W              = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_write,
    input  logic [REG_W-1:0] id_writeReg,
    input  logic [REG_W-1:0] id_readReg0,
    input  logic [REG_W-1:0] id_readReg1,
    input  logic             id_immediate,
    input  logic             id_ReadMem,
    input  logic             id_WriteMem,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       hazard_src,
    output logic [CNT_W-1:0] stall_count,
    output logic             sb_busy
);

    sb_entry_t [DEPTH-1:0] sb_r;
    sb_entry_t [DEPTH-1:0] sb_next_s;
    logic                  sb_busy_r;
    logic                  busy_next_s;
    logic [CNT_W-1:0]      stall_count_r;
    logic                  use0_s;
    logic                  use1_s;
    logic                  conflict0_s;
    logic                  conflict1_s;
    logic                  stall_s;

    // readReg1 only matters for register-register ops and store data
    assign use0_s = id_valid;
    assign use1_s = id_valid & (~id_immediate | id_WriteMem);

    sb_compare #(
        .DEPTH              (DEPTH),
        .FORWARD            (FORWARD),
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_cmp0 (
        .sb_entries_s (sb_r),
        .reg_sel_s    (id_readReg0),
        .use_op_s     (use0_s),
        .conflict_s   (conflict0_s)
    );

    sb_compare #(
        .DEPTH              (DEPTH),
        .FORWARD            (FORWARD),
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_cmp1 (
        .sb_entries_s (sb_r),
        .reg_sel_s    (id_readReg1),
        .use_op_s     (use1_s),
        .conflict_s   (conflict1_s)
    );

    assign stall_s     = (conflict0_s | conflict1_s) & ~flush;
    assign hazard_src  = {conflict1_s, conflict0_s};
    assign stall       = stall_s;
    assign bubble      = stall_s;
    assign stall_count = stall_count_r;
    assign sb_busy     = sb_busy_r;

    // Scoreboard next state: flush clears, stall injects a bubble, else accept ID
    always_comb begin
        sb_next_s = sb_r;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_next_s[k] = sb_bubble();
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb_next_s[k] = sb_r[k-1];
            end
            if (stall_s) begin
                sb_next_s[STG_EX] = sb_bubble();
            end else begin
                sb_next_s[STG_EX].v  = id_valid;
                sb_next_s[STG_EX].wr = id_write & id_valid;
                sb_next_s[STG_EX].rd = id_writeReg;
                sb_next_s[STG_EX].ld = id_ReadMem & id_valid;
            end
        end
    end

    // Busy flag is computed from the next scoreboard so it can be registered
    always_comb begin
        busy_next_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_next_s = busy_next_s | sb_entry_busy(sb_next_s[k]);
        end
    end

    // Scoreboard, busy flag and saturating stall counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_r[k] <= sb_bubble();
            end
            sb_busy_r     <= 1'b0;
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            sb_r      <= sb_next_s;
            sb_busy_r <= busy_next_s;
            if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: four parameterisations share one stimulus stream, each
// checked where its configuration gives a distinct expected result.
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic       id_write;
    logic [3:0] id_writeReg;
    logic [3:0] id_readReg0;
    logic [3:0] id_readReg1;
    logic       id_immediate;
    logic       id_ReadMem;
    logic       id_WriteMem;
    logic       flush;

    logic        f1_stall, f1_bubble, f1_busy;
    logic [1:0]  f1_hz;
    logic [15:0] f1_cnt;
    logic        f0_stall, f0_bubble, f0_busy;
    logic [1:0]  f0_hz;
    logic [15:0] f0_cnt;
    logic        z0_stall, z0_bubble, z0_busy;
    logic [1:0]  z0_hz;
    logic [15:0] z0_cnt;
    logic        st_stall, st_bubble, st_busy;
    logic [1:0]  st_hz;
    logic [3:0]  st_cnt;

    int total = 0;
    int bad   = 0;

    hazard_stall_unit #(.DEPTH(3), .FORWARD(1), .ZERO_REG_HARDWIRED(1), .CNT_W(16)) u_f1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_write(id_write),
        .id_writeReg(id_writeReg), .id_readReg0(id_readReg0), .id_readReg1(id_readReg1),
        .id_immediate(id_immediate), .id_ReadMem(id_ReadMem), .id_WriteMem(id_WriteMem),
        .flush(flush), .stall(f1_stall), .bubble(f1_bubble), .hazard_src(f1_hz),
        .stall_count(f1_cnt), .sb_busy(f1_busy));

    hazard_stall_unit #(.DEPTH(3), .FORWARD(0), .ZERO_REG_HARDWIRED(1), .CNT_W(16)) u_f0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_write(id_write),
        .id_writeReg(id_writeReg), .id_readReg0(id_readReg0), .id_readReg1(id_readReg1),
        .id_immediate(id_immediate), .id_ReadMem(id_ReadMem), .id_WriteMem(id_WriteMem),
        .flush(flush), .stall(f0_stall), .bubble(f0_bubble), .hazard_src(f0_hz),
        .stall_count(f0_cnt), .sb_busy(f0_busy));

    hazard_stall_unit #(.DEPTH(3), .FORWARD(1), .ZERO_REG_HARDWIRED(0), .CNT_W(16)) u_z0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_write(id_write),
        .id_writeReg(id_writeReg), .id_readReg0(id_readReg0), .id_readReg1(id_readReg1),
        .id_immediate(id_immediate), .id_ReadMem(id_ReadMem), .id_WriteMem(id_WriteMem),
        .flush(flush), .stall(z0_stall), .bubble(z0_bubble), .hazard_src(z0_hz),
        .stall_count(z0_cnt), .sb_busy(z0_busy));

    hazard_stall_unit #(.DEPTH(3), .FORWARD(0), .ZERO_REG_HARDWIRED(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_write(id_write),
        .id_writeReg(id_writeReg), .id_readReg0(id_readReg0), .id_readReg1(id_readReg1),
        .id_immediate(id_immediate), .id_ReadMem(id_ReadMem), .id_WriteMem(id_WriteMem),
        .flush(flush), .stall(st_stall), .bubble(st_bubble), .hazard_src(st_hz),
        .stall_count(st_cnt), .sb_busy(st_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic w, input logic [3:0] wreg,
                           input logic [3:0] r0, input logic [3:0] r1,
                           input logic imm, input logic rdm, input logic wrm);
        id_valid     = v;
        id_write     = w;
        id_writeReg  = wreg;
        id_readReg0  = r0;
        id_readReg1  = r1;
        id_immediate = imm;
        id_ReadMem   = rdm;
        id_WriteMem  = wrm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        present(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        present(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_cnt", {16'd0, f1_cnt}, 32'd0);
        chk("reset_busy", {31'd0, f1_busy}, 32'd0);
        chk("reset_stall", {31'd0, f1_stall}, 32'd0);
        rst_n = 1'b1;

        // load-use with forwarding: load r3, then add r5 <- r3, r4
        present(1'b1, 1'b1, 4'd3, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0);
        chk("lu_first_nostall", {31'd0, f1_stall}, 32'd0);
        tick();
        present(1'b1, 1'b1, 4'd5, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
        chk("lu_stall", {31'd0, f1_stall}, 32'd1);
        chk("lu_hz", {30'd0, f1_hz}, 32'd1);
        chk("lu_bubble", {31'd0, f1_bubble}, 32'd1);
        tick();
        chk("lu_cnt1", {16'd0, f1_cnt}, 32'd1);
        chk("lu_release", {31'd0, f1_stall}, 32'd0);
        chk("lu_release_hz", {30'd0, f1_hz}, 32'd0);
        tick();
        chk("lu_cnt_once", {16'd0, f1_cnt}, 32'd1);
        chk("lu_busy", {31'd0, f1_busy}, 32'd1);
        clear_all();

        // no forwarding: dependency on EX stalls three cycles
        present(1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        present(1'b1, 1'b1, 4'd6, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("nf_stall_c1", {31'd0, f0_stall}, 32'd1);
        chk("nf_hz", {30'd0, f0_hz}, 32'd1);
        chk("fw_alu_nostall", {31'd0, f1_stall}, 32'd0);
        tick();
        chk("nf_stall_c2", {31'd0, f0_stall}, 32'd1);
        tick();
        chk("nf_stall_c3", {31'd0, f0_stall}, 32'd1);
        tick();
        chk("nf_release", {31'd0, f0_stall}, 32'd0);
        chk("nf_cnt5", {16'd0, f0_cnt}, 32'd5);
        tick();
        chk("nf_accept_cnt", {16'd0, f0_cnt}, 32'd5);
        chk("nf_accept_busy", {31'd0, f0_busy}, 32'd1);
        clear_all();

        // no forwarding: dependency at distance 2 stalls two cycles
        present(1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        present(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        present(1'b1, 1'b1, 4'd6, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("d2_stall_c1", {31'd0, f0_stall}, 32'd1);
        tick();
        chk("d2_stall_c2", {31'd0, f0_stall}, 32'd1);
        tick();
        chk("d2_release", {31'd0, f0_stall}, 32'd0);
        chk("d2_cnt7", {16'd0, f0_cnt}, 32'd7);
        clear_all();

        // invalid ID and immediate masking against a pending load of r3
        present(1'b1, 1'b1, 4'd3, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0);
        tick();
        present(1'b0, 1'b1, 4'd7, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
        chk("invalid_nostall", {31'd0, f1_stall}, 32'd0);
        present(1'b1, 1'b1, 4'd7, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0);
        chk("imm_nostall", {31'd0, f1_stall}, 32'd0);
        chk("imm_hz", {30'd0, f1_hz}, 32'd0);
        present(1'b1, 1'b0, 4'd0, 4'd1, 4'd3, 1'b1, 1'b0, 1'b1);
        chk("store_stall", {31'd0, f1_stall}, 32'd1);
        chk("store_hz", {30'd0, f1_hz}, 32'd2);
        clear_all();

        // zero register, then flush against a live conflict
        present(1'b1, 1'b1, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0);
        tick();
        chk("z0_busy", {31'd0, z0_busy}, 32'd1);
        present(1'b1, 1'b1, 4'd5, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0);
        chk("zero_hw_nostall", {31'd0, f1_stall}, 32'd0);
        chk("zero_sw_stall", {31'd0, z0_stall}, 32'd1);
        chk("zero_sw_hz", {30'd0, z0_hz}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_nostall", {31'd0, z0_stall}, 32'd0);
        chk("flush_nobubble", {31'd0, z0_bubble}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, z0_busy}, 32'd0);
        chk("flush_cnt", {16'd0, z0_cnt}, 32'd1);

        // asynchronous reset between clock edges with a pending hazard
        present(1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        present(1'b1, 1'b1, 4'd6, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_stall", {31'd0, f0_stall}, 32'd1);
        chk("pre_rst_cnt", {16'd0, f0_cnt}, 32'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", {16'd0, f0_cnt}, 32'd0);
        chk("arst_busy", {31'd0, f0_busy}, 32'd0);
        chk("arst_stall", {31'd0, f0_stall}, 32'd0);
        chk("arst_hz", {30'd0, f0_hz}, 32'd0);
        present(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // repeated self-feeding dependency: 22 stalls in 30 edges
        present(1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        repeat (30) tick();
        chk("sat_cnt", {28'd0, st_cnt}, 32'hF);
        chk("nosat_cnt", {16'd0, f0_cnt}, 32'd22);
        chk("fw_nosat_cnt", {16'd0, f1_cnt}, 32'd0);
        present(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
